exception_vector_fetch: RTL and testbench

EXCEPTION_VECTOR_FETCH -- requirements
Module: exception_vector_fetch

---
 rtl/exception_vector_fetch.sv | 118 +++++++++++
 tb/tb_exception_vector_fetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exception_vector_fetch.sv
// exception_vector_fetch: saves EPC, selects the exception vector address, waits for memory, then loads the handler PC.
module exception_vector_fetch #(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [2:0]  mem_addr_sel,
  output logic        epc_write,
  output logic [31:0] epc_out,
  output logic        pc_write,
  output logic [31:0] pc_out,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {S_IDLE, S_SAVE_EPC, S_ADDR, S_WAIT, S_LOAD_PC} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        epc_write_q, epc_write_d;
  logic [31:0] epc_q, epc_d;
  logic        pc_write_q, pc_write_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cause_q, cause_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        unused_mem_hi;
  assign unused_mem_hi = ^mem_data[31:8];
  // cause codes 01/10/11 map directly onto address selects 010/011/100
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    epc_write_d = 1'b0;
    epc_d       = epc_q;
    pc_write_d  = 1'b0;
    pc_d        = pc_q;
    cause_d     = cause_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: if (exc_opcode || exc_overflow || exc_div0) begin
        state_d     = S_SAVE_EPC;
        cause_d     = exc_opcode ? 2'd1 : exc_overflow ? 2'd2 : 2'd3;
        epc_write_d = 1'b1;
        epc_d       = pc_in - 32'd4;
        busy_d      = 1'b1;
        sel_d       = 3'd0;
      end
      S_SAVE_EPC: begin
        state_d = S_ADDR;
        sel_d   = {1'b0, cause_q} + 3'd1;
      end
      S_ADDR: begin
        state_d = S_WAIT;
        cnt_d   = 3'(MEM_WAIT);
      end
      S_WAIT: if (cnt_q == 3'd1) begin
        state_d    = S_LOAD_PC;
        cnt_d      = 3'd0;
        sel_d      = 3'd0;
        pc_write_d = 1'b1;
        pc_d       = {24'd0, mem_data[7:0]};
        done_d     = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      S_LOAD_PC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sel_d   = 3'd0;
        cnt_d   = 3'd0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      sel_q       <= 3'd0;
      epc_write_q <= 1'b0;
      epc_q       <= 32'd0;
      pc_write_q  <= 1'b0;
      pc_q        <= 32'd0;
      cause_q     <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      epc_write_q <= epc_write_d;
      epc_q       <= epc_d;
      pc_write_q  <= pc_write_d;
      pc_q        <= pc_d;
      cause_q     <= cause_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign mem_addr_sel = sel_q;
  assign epc_write    = epc_write_q;
  assign epc_out      = epc_q;
  assign pc_write     = pc_write_q;
  assign pc_out       = pc_q;
  assign cause        = cause_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_exception_vector_fetch.sv
// tb_exception_vector_fetch: table vectors, hand sequences and random stimulus against a timeline model.
module tb_exception_vector_fetch;
  localparam int MW = 2;
  logic clk = 1'b0;
  logic reset;
  logic exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in, mem_data;
  logic [2:0] sel0, sel1, sel7;
  logic ew0, ew1, ew7, pw0, pw1, pw7, busy0, busy1, busy7, done0, done1, done7;
  logic [31:0] epc0, epc1, epc7, pco0, pco1, pco7;
  logic [1:0] cause0, cause1, cause7;
  always #5 clk = ~clk;
  exception_vector_fetch #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data(mem_data), .mem_addr_sel(sel0), .epc_write(ew0), .epc_out(epc0),
    .pc_write(pw0), .pc_out(pco0), .cause(cause0), .busy(busy0), .done(done0));
  exception_vector_fetch #(.MEM_WAIT(1)) dut_w1 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data(mem_data), .mem_addr_sel(sel1), .epc_write(ew1), .epc_out(epc1),
    .pc_write(pw1), .pc_out(pco1), .cause(cause1), .busy(busy1), .done(done1));
  exception_vector_fetch #(.MEM_WAIT(7)) dut_w7 (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data(mem_data), .mem_addr_sel(sel7), .epc_write(ew7), .epc_out(epc7),
    .pc_write(pw7), .pc_out(pco7), .cause(cause7), .busy(busy7), .done(done7));
  int n_cmp = 0;
  int n_bad = 0;
  // model: t = cycle index within the sequence (0 = idle, 1 = EPC save, ..., 3+MW = PC load)
  int t;
  logic [1:0] m_cause;
  logic [31:0] m_epc, m_pc;
  typedef struct {
    logic [2:0]  exc;
    logic [31:0] pc;
    logic [31:0] md;
    logic [1:0]  cause;
    logic [2:0]  sel;
    logic [31:0] epc;
    logic [31:0] pco;
  } vec_t;
  vec_t vecs[6];
  function automatic logic [72:0] exp_vec();
    logic [2:0] s;
    s = (t >= 2 && t <= 2 + MW) ? {1'b0, m_cause} + 3'd1 : 3'd0;
    return {s, t == 1, m_epc, t == 3 + MW, m_pc, m_cause, t != 0, t == 3 + MW};
  endfunction
  task automatic chk(string nm, logic [72:0] act, logic [72:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    chk(nm, {41'd0, act}, {41'd0, exp});
  endtask
  task automatic check_outputs(string nm);
    chk(nm, {sel0, ew0, epc0, pw0, pco0, cause0, busy0, done0}, exp_vec());
  endtask
  task automatic model_reset();
    t = 0;
    m_cause = 2'd0;
    m_epc = 32'd0;
    m_pc = 32'd0;
  endtask
  task automatic step();
    if (t == 0) begin
      if (exc_opcode || exc_overflow || exc_div0) begin
        t = 1;
        m_cause = exc_opcode ? 2'd1 : exc_overflow ? 2'd2 : 2'd3;
        m_epc = pc_in - 32'd4;
      end
    end else if (t == 3 + MW) begin
      t = 0;
    end else begin
      if (t == 2 + MW) m_pc = {24'd0, mem_data[7:0]};
      t++;
    end
    @(posedge clk);
    #1;
    check_outputs("cycle outputs");
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 check_outputs("async reset");
    @(posedge clk);
    #1 reset = 1'b0;
    check_outputs("reset release");
  endtask
  task automatic run_vec(vec_t v);
    int done_k, sel_cycles;
    logic [2:0] seen;
    done_k = 0;
    sel_cycles = 0;
    seen = 3'd0;
    pc_in = v.pc;
    mem_data = v.md;
    {exc_opcode, exc_overflow, exc_div0} = v.exc;
    step();
    {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    for (int k = 2; k <= 20 && done_k == 0; k++) begin
      exc_div0 = (k == 3);
      step();
      if (sel0 != 3'd0) begin
        if (seen != 3'd0 && seen != sel0) chk("sel constant", {70'd0, sel0}, {70'd0, seen});
        seen = sel0;
        sel_cycles++;
      end
      if (done0) done_k = k;
    end
    exc_div0 = 1'b0;
    chk32("latency", done_k, 3 + MW);
    chk32("sel cycles", sel_cycles, 1 + MW);
    chk32("sel code", {29'd0, seen}, {29'd0, v.sel});
    chk32("cause", {30'd0, cause0}, {30'd0, v.cause});
    chk32("epc_out", epc0, v.epc);
    chk32("pc_out", pco0, v.pco);
    step();
    step();
  endtask
  initial begin
    int lat1, lat7;
    vecs[0] = '{3'b100, 32'h40, 32'h80, 2'd1, 3'd2, 32'h3C, 32'h80};
    vecs[1] = '{3'b011, 32'h1000, 32'h12345677, 2'd2, 3'd3, 32'hFFC, 32'h77};
    vecs[2] = '{3'b001, 32'h200, 32'hFFFFFF2C, 2'd3, 3'd4, 32'h1FC, 32'h2C};
    vecs[3] = '{3'b100, 32'h0, 32'h11, 2'd1, 3'd2, 32'hFFFFFFFC, 32'h11};
    vecs[4] = '{3'b111, 32'h8, 32'hAB, 2'd1, 3'd2, 32'h4, 32'hAB};
    vecs[5] = '{3'b010, 32'hFFFFFFFF, 32'h0, 2'd2, 3'd3, 32'hFFFFFFFB, 32'h0};
    {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    pc_in = 32'd0;
    mem_data = 32'd0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    exc_overflow = 1'b1;
    pc_in = 32'h500;
    mem_data = 32'h9;
    for (int i = 0; i < 2 * (3 + MW) + 2; i++) step();
    exc_overflow = 1'b0;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    exc_opcode = 1'b1;
    pc_in = 32'h300;
    step();
    exc_opcode = 1'b0;
    step();
    step();
    step();
    do_reset();
    chk32("cause after abort", {30'd0, cause0}, 32'd0);
    run_vec(vecs[0]);
    do_reset();
    lat1 = 0;
    lat7 = 0;
    exc_opcode = 1'b1;
    step();
    exc_opcode = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      step();
      if (pw1 && lat1 == 0) lat1 = k;
      if (pw7 && lat7 == 0) lat7 = k;
    end
    chk32("latency MEM_WAIT=1", lat1, 4);
    chk32("latency MEM_WAIT=7", lat7, 10);
    for (int i = 0; i < 600; i++) begin
      exc_opcode = ($urandom_range(0, 5) == 0);
      exc_overflow = ($urandom_range(0, 5) == 0);
      exc_div0 = ($urandom_range(0, 5) == 0);
      pc_in = $urandom;
      mem_data = $urandom;
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
